ht_pattern_tester: RTL and testbench
====================================

# ht_pattern_tester

Sequential stimulus/response engine at the driving end of a small combinational circuit under test (CUT). It applies every input pattern to the CUT, samples the CUT outputs, and compacts them into a MISR signature. It compares that signature against a golden value and reports pass/fail, so trojan-induced deviations in the CUT show up as a signature mismatch. Optionally it counts rare-node activations: patterns that drive any CUT output high.

## Interface
- N_IN, 4, CUT input width; pattern space is 2^N_IN
- N_OUT, 4, CUT output width; N_OUT <= SIG_W
- SIG_W, 16, MISR/signature width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a test run; sampled only in IDLE
- golden_sig  in  SIG_W  expected signature; sampled at the final capture
- pat_out  out  N_IN  pattern driven to CUT inputs
- resp_in  in  N_OUT  CUT outputs; combinational function of pat_out
- busy  out  1  high in APPLY/CAPTURE
- done  out  1  one-cycle pulse in DONE
- pass  out  1  signature == golden_sig; valid from done until next start
- signature  out  SIG_W  MISR contents
- rare_cnt  out  N_IN+1  count of captures with resp_in != 0

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE:
  - On start=1: seed the MISR to MISR_SEED, clear rare_cnt, set pat_out=0, clear pass, go to APPLY.
  - Otherwise hold all outputs.
- APPLY: hold pat_out for one settle cycle, then go to CAPTURE.
- CAPTURE: on the clock edge:
  - Update the MISR: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ zero-extended resp_in.
  - Increment rare_cnt if resp_in != 0.
  - If pat_out == 2^N_IN-1: register pass = (sig_next == golden_sig) and go to DONE.
  - Else: pat_out += 1 and go to APPLY.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored outside IDLE. A start held high through DONE begins a new run only from the IDLE cycle that follows.
- Signature, pass and rare_cnt hold their values in IDLE until the next accepted start.
- pat_out never wraps within a run. Compare pat_out against the all-ones value, not against an overflow.

## Timing
- Reset values: state IDLE, pat_out 0, busy 0, done 0, pass 0, signature 0, rare_cnt 0.
- Reset asserted mid-run: immediate asynchronous return to the reset values; no partial result is reported.
- Cycle count, with edge 0 as the edge that samples start:
  - APPLY for pattern k occupies the cycle after edge 2k.
  - Capture of pattern k happens at edge 2k+2.
  - done is high in the cycle after edge 2^(N_IN+1); for the defaults, 32 cycles after start.
- busy is high from the cycle after edge 0 through the last CAPTURE cycle.
- resp_in must settle within the APPLY cycle; it is sampled only at CAPTURE edges.

## Configuration
- HT_RARE_CNT_EN defined: the rare-activation counter is built and behaves as described.
- HT_RARE_CNT_EN undefined: no counter logic; rare_cnt is tied to 0. All other behaviour is identical.

## Structure
- Package ht_test_pkg:
  - state enum (IDLE, APPLY, CAPTURE, DONE)
  - MISR_POLY = 16'h1021
  - MISR_SEED = 16'hFFFF
- Sub-module ht_misr:
  - Inputs: clk, rst_n, seed, en, data.
  - Output: sig.
  - Holds the shift/feedback register, so it can be reused for other CUT widths.
- Top level holds the FSM, the pattern counter, the rare counter and the compare.

## Test plan
- Fault-free CUT model (all outputs = A&B&C&D), golden_sig from the bench model, start pulse:
  - done at cycle 32, pass=1, rare_cnt=1 (pattern 4'hF only).
  - pat_out steps 0..15, changing every 2 cycles.
- Trojan model forcing output bit 3 high on pattern 4'hA, same golden_sig: pass=0, rare_cnt=2, signature differs from golden.
- resp_in tied to 0: rare_cnt=0, signature equals the model's zero-input value from seed 16'hFFFF, pass=0 against the fault-free golden.
- start pulsed at cycles 5 and 20 during a run, and held high through DONE:
  - Mid-run pulses ignored, single done at cycle 32.
  - New run starts with pat_out=0 after the IDLE cycle.
- rst_n pulsed low at cycle 10 of a run: outputs return to reset values immediately, no done; a following start gives a full correct run.
- Build without HT_RARE_CNT_EN and repeat the first scenario: rare_cnt=0, signature and pass unchanged.

Source files
------------

// File: rtl/ht_test_pkg.sv
// Shared types and constants for the hardware-trojan pattern tester.
package ht_test_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // CCITT feedback taps; seed of all ones so a CUT stuck at zero still
    // produces a non-trivial signature.
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/ht_misr.sv
// Multiple-input signature register: shift left with polynomial feedback from
// the MSB, XORing in a zero-extended response word on every enabled cycle.
// The next-state value is exported so the caller can compare it against a
// golden signature in the same cycle the final response is folded in.
module ht_misr
    import ht_test_pkg::*;
#(
    parameter int               SIG_W  = 16,
    parameter int               DATA_W = 4,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(MISR_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(MISR_SEED)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  sig,
    output logic [SIG_W-1:0]  sig_next
);

    assign sig_next = {sig[SIG_W-2:0], 1'b0}
                    ^ (sig[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(data);

    // Signature register: seed load takes priority over compaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (seed) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/ht_pattern_tester.sv
// Exhaustive stimulus/response engine for a small combinational CUT.
// Walks every input pattern (one settle cycle, one capture cycle each),
// compacts the CUT responses in a MISR and compares the final signature
// against golden_sig.
// Build option: define HT_RARE_CNT_EN to build the rare-activation counter
// (captures with any CUT output high); otherwise rare_cnt is tied to zero.
module ht_pattern_tester
    import ht_test_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [N_IN-1:0]  pat_out,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [N_IN:0]    rare_cnt
);

    localparam logic [N_IN-1:0] PAT_LAST = '1;
    localparam logic [N_IN-1:0] PAT_ONE  = N_IN'(1);

    state_t           state, state_n;
    logic             misr_seed;
    logic             misr_en;
    logic [SIG_W-1:0] sig_next;
    logic             start_acc;
    logic             capture;
    logic             last_pat;

    assign start_acc = (state == IDLE) && start;
    assign capture   = (state == CAPTURE);
    assign last_pat  = (pat_out == PAT_LAST);

    ht_misr #(
        .SIG_W  (SIG_W),
        .DATA_W (N_OUT),
        .POLY   (SIG_W'(MISR_POLY)),
        .SEED   (SIG_W'(MISR_SEED))
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (misr_seed),
        .en       (misr_en),
        .data     (resp_in),
        .sig      (signature),
        .sig_next (sig_next)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode plus MISR control and status outputs.
    always_comb begin
        state_n   = state;
        misr_seed = 1'b0;
        misr_en   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    misr_seed = 1'b1;
                    state_n   = APPLY;
                end
            end
            APPLY: begin
                busy    = 1'b1;
                state_n = CAPTURE;
            end
            CAPTURE: begin
                busy    = 1'b1;
                misr_en = 1'b1;
                state_n = last_pat ? DONE : APPLY;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Pattern counter: cleared on an accepted start, advanced after each
    // non-final capture; it stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_out <= '0;
        end else if (start_acc) begin
            pat_out <= '0;
        end else if (capture && !last_pat) begin
            pat_out <= pat_out + PAT_ONE;
        end
    end

    // Verdict: cleared on start, registered at the final capture using the
    // signature that includes the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (start_acc) begin
            pass <= 1'b0;
        end else if (capture && last_pat) begin
            pass <= (sig_next == golden_sig);
        end
    end

`ifdef HT_RARE_CNT_EN
    localparam logic [N_IN:0] CNT_ONE = (N_IN + 1)'(1);

    // Rare-activation counter: one count per capture with any output high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rare_cnt <= '0;
        end else if (start_acc) begin
            rare_cnt <= '0;
        end else if (capture && (resp_in != '0)) begin
            rare_cnt <= rare_cnt + CNT_ONE;
        end
    end
`else
    assign rare_cnt = '0;
`endif

endmodule

// File: tb/tb_ht_pattern_tester.sv
// Directed bench for ht_pattern_tester with a behavioural 4-in/4-out CUT.
// Expected signatures (seed FFFF, poly 1021, 16 captures):
//   all-zero responses          -> 1D0F
//   fault-free (4'hF at pat F)  -> 1D00
//   trojan (+4'h8 at pat A)     -> 1C00
module tb_ht_pattern_tester;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] golden_sig;
    logic [3:0]  pat_out;
    logic [3:0]  resp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [4:0]  rare_cnt;
    logic [1:0]  cut_mode;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] SIG_GOOD   = 16'h1D00;
    localparam logic [15:0] SIG_TROJAN = 16'h1C00;
    localparam logic [15:0] SIG_ZERO   = 16'h1D0F;

    ht_pattern_tester dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .golden_sig (golden_sig),
        .pat_out    (pat_out),
        .resp_in    (resp_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .rare_cnt   (rare_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CUT model: 0 fault-free AND, 1 trojan on pattern A, other = stuck zero.
    always_comb begin
        resp_in = 4'h0;
        case (cut_mode)
            2'd0: resp_in = (&pat_out) ? 4'hF : 4'h0;
            2'd1: begin
                resp_in = (&pat_out) ? 4'hF : 4'h0;
                if (pat_out == 4'hA) resp_in[3] = 1'b1;
            end
            default: resp_in = 4'h0;
        endcase
    end

    function automatic int exp_rare(input int r);
`ifdef HT_RARE_CNT_EN
        return r;
`else
        return 0 * r;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pat"},  pat_out,   0);
        chk({tag, "_busy"}, busy,      0);
        chk({tag, "_done"}, done,      0);
        chk({tag, "_pass"}, pass,      0);
        chk({tag, "_sig"},  signature, 0);
        chk({tag, "_rare"}, rare_cnt,  0);
    endtask

    // Pulse start for one edge; returns at the negedge after that edge.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows a run from the negedge after the start-sampling edge.
    task automatic follow(input logic [15:0] exp_sig, input logic exp_pass,
                          input int rare, input bit mid, input bit hold);
        chk("start_busy", busy,      1);
        chk("start_pat",  pat_out,   0);
        chk("start_sig",  signature, 16'hFFFF);
        chk("start_pass", pass,      0);
        chk("start_rare", rare_cnt,  0);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n < 32) begin
                chk("step_pat",  pat_out, n / 2);
                chk("step_busy", busy,    1);
                chk("step_done", done,    0);
            end else begin
                chk("end_done", done,      1);
                chk("end_busy", busy,      0);
                chk("end_sig",  signature, exp_sig);
                chk("end_pass", pass,      exp_pass);
                chk("end_rare", rare_cnt,  exp_rare(rare));
            end
            start = (mid && (n == 4 || n == 19)) || (hold && n >= 31);
        end
        @(negedge clk);
        chk("idle_done", done,      0);
        chk("idle_busy", busy,      0);
        chk("idle_sig",  signature, exp_sig);
        chk("idle_pass", pass,      exp_pass);
        chk("idle_pat",  pat_out,   15);
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        start      = 1'b0;
        golden_sig = SIG_GOOD;
        cut_mode   = 2'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset_idle");

        // Fault-free CUT.
        kick();
        follow(SIG_GOOD, 1'b1, 1, 1'b0, 1'b0);

        // Trojan on pattern A against the fault-free golden.
        cut_mode = 2'd1;
        kick();
        follow(SIG_TROJAN, 1'b0, 2, 1'b0, 1'b0);

        // Responses stuck at zero.
        cut_mode = 2'd2;
        kick();
        follow(SIG_ZERO, 1'b0, 0, 1'b0, 1'b0);

        // Mid-run start pulses ignored; start held through DONE relaunches.
        cut_mode = 2'd0;
        kick();
        follow(SIG_GOOD, 1'b1, 1, 1'b1, 1'b1);
        follow(SIG_GOOD, 1'b1, 1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run.
        cut_mode = 2'd1;
        kick();
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_activity_after_reset", seen, 0);
        chk("held_sig_after_reset", signature, 0);

        cut_mode = 2'd0;
        kick();
        follow(SIG_GOOD, 1'b1, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
